// File: rtl/xfer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xfer_pkg
// Description : Shared FSM state encoding and default geometry for the
//               xfer_reader capture path.
// Revision    : 1.0 - initial release
// ============================================================================
package xfer_pkg;

  localparam int c_DEF_WIDTH  = 32;
  localparam int c_DEF_DEPTH  = 4;
  localparam int c_DEF_SETTLE = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_FULLWAIT = 2'd2,
    ST_ACK      = 2'd3
  } xfer_state_e;

endpackage : xfer_pkg
`default_nettype wire

// File: rtl/xfer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : xfer_fifo
// Description : First-word fall-through FIFO. Occupancy counter tells full
//               from empty; pointers wrap naturally modulo DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module xfer_fifo
  import xfer_pkg::*;
#(
  parameter int WIDTH = c_DEF_WIDTH,
  parameter int DEPTH = c_DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q,  level_d;
  logic             pop_ok;
  logic             push_ok;

  // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
  always_comb begin
    pop_ok   = pop && (level_q != '0);
    push_ok  = push && ((level_q != LW'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
    else if (pop_ok && !push_ok) level_d = level_q - LW'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign level     = level_q;
  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q];

endmodule : xfer_fifo
`default_nettype wire

// File: rtl/xfer_reader.sv
`default_nettype none
// ============================================================================
// Module      : xfer_reader
// Description : Captures words from a shared bus under a 4-phase req/ack
//               handshake, waiting for SETTLE identical samples before
//               pushing the word into an output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module xfer_reader
  import xfer_pkg::*;
#(
  parameter int WIDTH  = c_DEF_WIDTH,
  parameter int DEPTH  = c_DEF_DEPTH,
  parameter int SETTLE = c_DEF_SETTLE
) (
  input  logic                       clk,
  input  logic                       rst,
  inout  wire  [WIDTH-1:0]           bus,
  input  logic                       bus_req,
  output logic                       bus_ack,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [7:0]                 glitch_cnt,
  output logic [7:0]                 abort_cnt
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  xfer_state_e      state_q,  state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [7:0]       glitch_q, glitch_d;
  logic [7:0]       abort_q,  abort_d;
  logic             push;
  logic             push_ok;
  logic             bus_eq;

  // The remote writer owns the bus; this block only ever listens.
  assign bus = {WIDTH{1'bz}};

  xfer_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shadow_q),
    .pop       (out_valid && out_ready),
    .level     (level),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  // Room for one more word, counting a slot freed by a pop in this same cycle.
  assign push_ok = (level < LW'(DEPTH)) || (out_valid && out_ready);
  assign bus_eq  = (bus == shadow_q);

  // Handshake FSM: settle filter, back-pressure wait, and event counters.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    glitch_d = glitch_q;
    abort_d  = abort_q;
    push     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_req) begin
          shadow_d = bus;
          cnt_d    = CW'(SETTLE - 1);
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!bus_req) begin
          if (abort_q != 8'hff) abort_d = abort_q + 8'd1;
          state_d = ST_IDLE;
        end else if (!bus_eq) begin
          shadow_d = bus;
          cnt_d    = CW'(SETTLE - 1);
          if (glitch_q != 8'hff) glitch_d = glitch_q + 8'd1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (push_ok) begin
          push    = 1'b1;
          state_d = ST_ACK;
        end else begin
          state_d = ST_FULLWAIT;
        end
      end
      ST_FULLWAIT: begin
        if (!bus_req) begin
          if (abort_q != 8'hff) abort_d = abort_q + 8'd1;
          state_d = ST_IDLE;
        end else if (push_ok) begin
          push    = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!bus_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, shadow and counter registers; reset drops any in-flight word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
      glitch_q <= '0;
      abort_q  <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
      abort_q  <= abort_d;
    end
  end

  assign bus_ack    = (state_q == ST_ACK);
  assign glitch_cnt = glitch_q;
  assign abort_cnt  = abort_q;

endmodule : xfer_reader
`default_nettype wire

// File: tb/tb_xfer_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_xfer_reader
// Description : Directed self-checking bench for xfer_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xfer_reader;

  logic        clk;
  logic        rst;
  logic        bus_req;
  logic        out_ready;
  logic [31:0] bus_drv;
  wire  [31:0] bus_w;
  logic        bus_ack;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  level;
  logic [7:0]  glitch_cnt;
  logic [7:0]  abort_cnt;

  int n_cmp = 0;
  int n_err = 0;

  assign bus_w = bus_drv;

  xfer_reader #(
    .WIDTH  (32),
    .DEPTH  (4),
    .SETTLE (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_w),
    .bus_req    (bus_req),
    .bus_ack    (bus_ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .glitch_cnt (glitch_cnt),
    .abort_cnt  (abort_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step one rising edge, then settle 1 ns so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full handshake for one word, bounded wait for the acknowledge.
  task automatic xfer(input logic [31:0] w);
    bus_drv = w;
    bus_req = 1'b1;
    for (int i = 0; i < 20 && !bus_ack; i++) tick();
    if (!bus_ack) chk("xfer_ack_timeout", 64'(bus_ack), 64'd1);
    bus_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_q [4];
    logic        saw_ack;

    rst       = 1'b1;
    bus_req   = 1'b0;
    out_ready = 1'b0;
    bus_drv   = 32'h0;
    tick();
    tick();
    chk("rst_ack",    64'(bus_ack),    64'd0);
    chk("rst_valid",  64'(out_valid),  64'd0);
    chk("rst_level",  64'(level),      64'd0);
    chk("rst_glitch", 64'(glitch_cnt), 64'd0);
    chk("rst_abort",  64'(abort_cnt),  64'd0);
    rst = 1'b0;
    tick();

    // Stable handshake: ack three cycles after bus_req is first sampled.
    bus_drv = 32'hdeadbeef;
    bus_req = 1'b1;
    tick();
    chk("stb_ack_c1", 64'(bus_ack), 64'd0);
    tick();
    chk("stb_ack_c2", 64'(bus_ack), 64'd0);
    chk("stb_val_c2", 64'(out_valid), 64'd0);
    tick();
    chk("stb_ack_c3", 64'(bus_ack), 64'd1);
    chk("stb_valid",  64'(out_valid), 64'd1);
    chk("stb_data",   64'(out_data), 64'hdeadbeef);
    chk("stb_level",  64'(level), 64'd1);
    bus_req = 1'b0;
    tick();
    chk("stb_ack_drop", 64'(bus_ack), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stb_pop_level", 64'(level), 64'd0);

    // Glitch: first sample differs from the settled value.
    bus_drv = 32'h12345678;
    bus_req = 1'b1;
    tick();
    bus_drv = 32'hdeadbeef;
    tick();
    tick();
    chk("gl_ack_early", 64'(bus_ack), 64'd0);
    tick();
    chk("gl_ack",    64'(bus_ack), 64'd1);
    chk("gl_cnt",    64'(glitch_cnt), 64'd1);
    chk("gl_level",  64'(level), 64'd1);
    chk("gl_data",   64'(out_data), 64'hdeadbeef);
    bus_req = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("gl_pop_level", 64'(level), 64'd0);

    // Abort: bus_req high for a single cycle.
    bus_drv = 32'hcafef00d;
    bus_req = 1'b1;
    tick();
    bus_req = 1'b0;
    saw_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      saw_ack = saw_ack | bus_ack;
    end
    chk("ab_no_ack", 64'(saw_ack), 64'd0);
    chk("ab_cnt",    64'(abort_cnt), 64'd1);
    chk("ab_level",  64'(level), 64'd0);
    chk("ab_glitch", 64'(glitch_cnt), 64'd1);

    // Full: four words, fifth stalls until a pop frees a slot.
    xfer(32'ha0000000);
    xfer(32'ha1111111);
    xfer(32'ha2222222);
    xfer(32'ha3333333);
    chk("full_level", 64'(level), 64'd4);
    chk("full_head",  64'(out_data), 64'ha0000000);
    bus_drv = 32'ha4444444;
    bus_req = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("full_wait_ack",   64'(bus_ack), 64'd0);
    chk("full_wait_level", 64'(level), 64'd4);
    out_ready = 1'b1;
    chk("full_pop_head", 64'(out_data), 64'ha0000000);
    tick();
    out_ready = 1'b0;
    chk("full_push_level", 64'(level), 64'd4);
    chk("full_push_ack",   64'(bus_ack), 64'd1);
    chk("full_new_head",   64'(out_data), 64'ha1111111);
    bus_req = 1'b0;
    tick();

    // Simultaneous push and pop on the settle-completion cycle.
    bus_drv = 32'ha5555555;
    bus_req = 1'b1;
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("sim_level", 64'(level), 64'd4);
    chk("sim_ack",   64'(bus_ack), 64'd1);
    chk("sim_head",  64'(out_data), 64'ha2222222);
    bus_req = 1'b0;
    tick();

    // Drain: order preserved across the pointer wrap.
    exp_q[0] = 32'ha2222222;
    exp_q[1] = 32'ha3333333;
    exp_q[2] = 32'ha4444444;
    exp_q[3] = 32'ha5555555;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_%0d", i), 64'(out_data), 64'(exp_q[i]));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Reset mid-SETTLE with a word already queued.
    xfer(32'h11111111);
    bus_drv = 32'h22222222;
    bus_req = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_ack",    64'(bus_ack), 64'd0);
    chk("mrst_level",  64'(level), 64'd0);
    chk("mrst_valid",  64'(out_valid), 64'd0);
    chk("mrst_glitch", 64'(glitch_cnt), 64'd0);
    chk("mrst_abort",  64'(abort_cnt), 64'd0);
    chk("mrst_bus",    64'(bus_w), 64'h22222222);
    tick();
    rst = 1'b0;
    tick();
    chk("post_ack_c1", 64'(bus_ack), 64'd0);
    tick();
    chk("post_ack_c2", 64'(bus_ack), 64'd0);
    tick();
    chk("post_ack_c3", 64'(bus_ack), 64'd1);
    chk("post_data",   64'(out_data), 64'h22222222);
    chk("post_level",  64'(level), 64'd1);
    bus_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_xfer_reader
`default_nettype wire

// File: doc/xfer_reader.md
XFER_READER -- requirements
Module: xfer_reader

Interface
REQ-001 Parameter WIDTH, default 32: width of the shared data bus and output word.
REQ-002 Parameter DEPTH, default 4: output FIFO entries; SHALL be a power of two, at least 2.
REQ-003 Parameter SETTLE, default 2: consecutive identical bus samples required before capture; SHALL be at least 1.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port bus  inout  WIDTH  shared data net driven by the remote writer; this block SHALL always drive it high-Z.
REQ-007 Port bus_req  input  1  writer strobe: the bus holds a word; 4-phase handshake.
REQ-008 Port bus_ack  output  1  reader acknowledge for the 4-phase handshake.
REQ-009 Port out_valid  output  1  FIFO head valid.
REQ-010 Port out_ready  input  1  consumer accepts the head word.
REQ-011 Port out_data  output  WIDTH  FIFO head word; first-word fall-through.
REQ-012 Port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 Port glitch_cnt  output  8  saturating count of bus-instability restarts.
REQ-014 Port abort_cnt  output  8  saturating count of bus_req drops before capture.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, FULLWAIT and ACK.
REQ-016 IDLE: bus_ack=0; on bus_req=1, load shadow<=bus and cnt<=SETTLE-1, then go to SETTLE.
REQ-017 SETTLE, bus_req=0: go to IDLE and increment abort_cnt; nothing is pushed.
REQ-018 SETTLE, bus differs from shadow: shadow<=bus, cnt<=SETTLE-1, increment glitch_cnt, stay in SETTLE.
REQ-019 SETTLE, bus equals shadow and cnt>0: decrement cnt.
REQ-020 SETTLE, bus equals shadow and cnt==0: push shadow if push is permitted and go to ACK; otherwise go to FULLWAIT.
REQ-021 Push is permitted when level<DEPTH, or when level==DEPTH and out_valid&&out_ready in the same cycle (simultaneous pop frees a slot).
REQ-022 FULLWAIT: push shadow in the first cycle push is permitted, then go to ACK; bus_req=0 here SHALL abort as in REQ-017.
REQ-023 ACK: bus_ack=1; on bus_req=0, go to IDLE, with bus_ack=0 from the next cycle.
REQ-024 With SETTLE=2 and a stable bus, bus_ack SHALL rise 3 cycles after the first cycle bus_req is sampled high.
REQ-025 Push-to-out_valid latency SHALL be 1 cycle; on an empty FIFO, out_data SHALL equal the pushed word in that cycle.
REQ-026 A pop SHALL occur on out_valid&&out_ready; with a simultaneous push and pop, level SHALL be unchanged.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by level.
REQ-028 glitch_cnt and abort_cnt SHALL saturate at 255 and never wrap.
REQ-029 out_data SHALL be don't-care when out_valid=0.

Reset
REQ-030 rst=1 SHALL immediately force: state IDLE, bus_ack=0, out_valid=0, level=0, pointers=0, glitch_cnt=0, abort_cnt=0.
REQ-031 Reset during any handshake SHALL discard the in-flight word; no partial push.
REQ-032 After rst deasserts with bus_req already high, the block SHALL start a fresh capture from IDLE.

Structure
REQ-033 Package xfer_pkg SHALL hold the FSM state enum and the default WIDTH, DEPTH and SETTLE constants.
REQ-034 The FIFO SHALL be the sub-module xfer_fifo (push, pop, level, head data).
REQ-035 The FSM, shadow register and counters SHALL reside in xfer_reader.

Verification
REQ-036 Stable handshake: bus=32'hdeadbeef, bus_req=1 -> bus_ack rises 3 cycles later; out_data=32'hdeadbeef; level=1.
REQ-037 Glitch: bus goes 32'h12345678, then 32'hdeadbeef one cycle later, then stable -> glitch_cnt=1; only 32'hdeadbeef is pushed.
REQ-038 Abort: bus_req high for 1 cycle only -> abort_cnt=1, level=0, bus_ack never rises.
REQ-039 Full: push 4 words with out_ready=0, start a 5th -> FSM holds in FULLWAIT, bus_ack=0; one pop -> 5th pushed, order preserved across pointer wrap.
REQ-040 Simultaneous: level=4, FSM completing settle, out_ready=1 -> push and pop in the same cycle, level stays 4.
REQ-041 Reset mid-SETTLE: assert rst -> bus_ack=0, level=0, counters=0 immediately; bus is never driven (always high-Z).
